// File: rtl/rs_issue_select_pkg.sv
// Shared widths and constants for the reservation-station issue logic.
// PRF/ROB widths sit alongside the RS sizing so every stage agrees on them.
package rs_issue_select_pkg;

   localparam int PRF_WIDTH = 6;
   localparam int ROB_WIDTH = 5;

   localparam int RS_SIZE  = 16;
   localparam int RS_WIDTH = 4;
   localparam int MUL_LAT  = 4;

   localparam int NUM_SLOTS  = 5;
   localparam int SLOT_ALU0  = 0;
   localparam int SLOT_ALU1  = 1;
   localparam int SLOT_MUL   = 2;
   localparam int SLOT_MEM   = 3;
   localparam int SLOT_BCOND = 4;

endpackage

// File: rtl/rs_issue_select_if.sv
// Wake-up / issue bundle between the reservation station and the issue selector.
// The master side owns the wake-up vectors; the slave side returns the grants.
interface rs_issue_select_if #(
   parameter int RS_SIZE  = rs_issue_select_pkg::RS_SIZE,
   parameter int RS_WIDTH = rs_issue_select_pkg::RS_WIDTH
);
   import rs_issue_select_pkg::*;

   logic                          flush;
   logic [RS_SIZE-1:0]            wake_up_alu;
   logic [RS_SIZE-1:0]            wake_up_mul;
   logic [RS_SIZE-1:0]            wake_up_mem;
   logic [RS_SIZE-1:0]            wake_up_bcond;
   logic                          mem_stall;
   logic [RS_SIZE-1:0]            rs_use_en;
   logic [NUM_SLOTS-1:0]          issue_valid;
   logic [NUM_SLOTS*RS_WIDTH-1:0] issue_idx;
   logic                          mul_busy;

   modport master (
      output flush, wake_up_alu, wake_up_mul, wake_up_mem, wake_up_bcond, mem_stall,
      input  rs_use_en, issue_valid, issue_idx, mul_busy
   );

   modport slave (
      input  flush, wake_up_alu, wake_up_mul, wake_up_mem, wake_up_bcond, mem_stall,
      output rs_use_en, issue_valid, issue_idx, mul_busy
   );

endinterface

// File: rtl/rs_issue_select_rr_pick.sv
// Round-robin picker: first set request at or after 'start', wrapping at N.
module rr_pick #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         valid,
   output logic [W-1:0] idx
);

   logic [W-1:0] pos;

   // Scan offsets from farthest to nearest so the nearest hit wins last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         pos = W'((int'(start) + i) % N);
         if (req[pos]) begin
            valid = 1'b1;
            idx   = pos;
         end
      end
   end

endmodule

// File: rtl/rs_issue_select.sv
// Issue selector: picks up to two ALU ops and one each of MUL/MEM/BCOND per
// cycle from the reservation station, with per-class round-robin fairness.
module rs_issue_select #(
   parameter int RS_SIZE  = rs_issue_select_pkg::RS_SIZE,
   parameter int RS_WIDTH = rs_issue_select_pkg::RS_WIDTH,
   parameter int MUL_LAT  = rs_issue_select_pkg::MUL_LAT
) (
   input logic              clk,
   input logic              rst,
   rs_issue_select_if.slave bus
);
   import rs_issue_select_pkg::*;

   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

   logic [RS_WIDTH-1:0]           rr_alu, rr_mul, rr_mem, rr_bcond;
   logic [CNT_W-1:0]              mul_cnt;
   logic                          mul_busy;
   logic [RS_SIZE-1:0]            use_en_q;
   logic [NUM_SLOTS-1:0]          valid_q;
   logic [NUM_SLOTS*RS_WIDTH-1:0] idx_q;

   logic [RS_SIZE-1:0]  cand_alu, cand_mul, cand_mem, cand_bcond, alu1_req;
   logic [RS_WIDTH-1:0] alu1_start;
   logic                alu0_v, alu1_v, mul_v, mem_v, bcond_v;
   logic [RS_WIDTH-1:0] alu0_idx, alu1_idx, mul_idx, mem_idx, bcond_idx;

   logic [NUM_SLOTS-1:0]          grant;
   logic [NUM_SLOTS*RS_WIDTH-1:0] nxt_idx;
   logic [RS_SIZE-1:0]            nxt_use;

   function automatic logic [RS_WIDTH-1:0] next_ptr(input logic [RS_WIDTH-1:0] i);
      if (int'(i) == RS_SIZE - 1) return '0;
      return i + RS_WIDTH'(1);
   endfunction

   function automatic logic [RS_SIZE-1:0] decode(input logic [RS_WIDTH-1:0] i);
      return RS_SIZE'(1) << i;
   endfunction

   // Entries granted last cycle are masked until their wake-up drops.
   assign cand_alu   = bus.wake_up_alu   & ~use_en_q;
   assign cand_mul   = bus.wake_up_mul   & ~use_en_q;
   assign cand_mem   = bus.wake_up_mem   & ~use_en_q;
   assign cand_bcond = bus.wake_up_bcond & ~use_en_q;

   // Second ALU search starts just past ALU0 and never sees ALU0's entry.
   assign alu1_req   = cand_alu & ~decode(alu0_idx);
   assign alu1_start = next_ptr(alu0_idx);

   rr_pick #(.N(RS_SIZE), .W(RS_WIDTH)) u_pick_alu0 (
      .req(cand_alu), .start(rr_alu), .valid(alu0_v), .idx(alu0_idx));
   rr_pick #(.N(RS_SIZE), .W(RS_WIDTH)) u_pick_alu1 (
      .req(alu1_req), .start(alu1_start), .valid(alu1_v), .idx(alu1_idx));
   rr_pick #(.N(RS_SIZE), .W(RS_WIDTH)) u_pick_mul (
      .req(cand_mul), .start(rr_mul), .valid(mul_v), .idx(mul_idx));
   rr_pick #(.N(RS_SIZE), .W(RS_WIDTH)) u_pick_mem (
      .req(cand_mem), .start(rr_mem), .valid(mem_v), .idx(mem_idx));
   rr_pick #(.N(RS_SIZE), .W(RS_WIDTH)) u_pick_bcond (
      .req(cand_bcond), .start(rr_bcond), .valid(bcond_v), .idx(bcond_idx));

   assign mul_busy = (mul_cnt != '0);

   // Qualify picks with flush/busy/stall and build the next output image.
   always_comb begin
      grant             = '0;
      grant[SLOT_ALU0]  = alu0_v  & ~bus.flush;
      grant[SLOT_ALU1]  = alu1_v  & ~bus.flush;
      grant[SLOT_MUL]   = mul_v   & ~bus.flush & ~mul_busy;
      grant[SLOT_MEM]   = mem_v   & ~bus.flush & ~bus.mem_stall;
      grant[SLOT_BCOND] = bcond_v & ~bus.flush;

      nxt_idx = '0;
      nxt_use = '0;
      if (grant[SLOT_ALU0]) begin
         nxt_idx[SLOT_ALU0*RS_WIDTH +: RS_WIDTH] = alu0_idx;
         nxt_use = nxt_use | decode(alu0_idx);
      end
      if (grant[SLOT_ALU1]) begin
         nxt_idx[SLOT_ALU1*RS_WIDTH +: RS_WIDTH] = alu1_idx;
         nxt_use = nxt_use | decode(alu1_idx);
      end
      if (grant[SLOT_MUL]) begin
         nxt_idx[SLOT_MUL*RS_WIDTH +: RS_WIDTH] = mul_idx;
         nxt_use = nxt_use | decode(mul_idx);
      end
      if (grant[SLOT_MEM]) begin
         nxt_idx[SLOT_MEM*RS_WIDTH +: RS_WIDTH] = mem_idx;
         nxt_use = nxt_use | decode(mem_idx);
      end
      if (grant[SLOT_BCOND]) begin
         nxt_idx[SLOT_BCOND*RS_WIDTH +: RS_WIDTH] = bcond_idx;
         nxt_use = nxt_use | decode(bcond_idx);
      end
   end

   // Register the grants; a flush arrives here as an all-zero image.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= '0;
         idx_q    <= '0;
         use_en_q <= '0;
      end else begin
         valid_q  <= grant;
         idx_q    <= nxt_idx;
         use_en_q <= nxt_use;
      end
   end

   // Multiplier occupancy: load on grant, count down to idle.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         mul_cnt <= '0;
      end else if (grant[SLOT_MUL]) begin
         mul_cnt <= MUL_LOAD;
      end else if (mul_cnt != '0) begin
         mul_cnt <= mul_cnt - CNT_W'(1);
      end
   end

   // Round-robin pointers advance past the last entry each class granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_alu   <= '0;
         rr_mul   <= '0;
         rr_mem   <= '0;
         rr_bcond <= '0;
      end else begin
         if (grant[SLOT_ALU1]) begin
            rr_alu <= next_ptr(alu1_idx);
         end else if (grant[SLOT_ALU0]) begin
            rr_alu <= next_ptr(alu0_idx);
         end
         if (grant[SLOT_MUL]) begin
            rr_mul <= next_ptr(mul_idx);
         end
         if (grant[SLOT_MEM]) begin
            rr_mem <= next_ptr(mem_idx);
         end
         if (grant[SLOT_BCOND]) begin
            rr_bcond <= next_ptr(bcond_idx);
         end
      end
   end

   assign bus.rs_use_en   = use_en_q;
   assign bus.issue_valid = valid_q;
   assign bus.issue_idx   = idx_q;
   assign bus.mul_busy    = mul_busy;

endmodule

// File: tb/tb_rs_issue_select.sv
// Directed bench for rs_issue_select: walks ALU pairing, masking, wrap-around,
// multiplier occupancy, memory stall, flush and reset with hand-computed results.
module tb_rs_issue_select;

   logic clk = 1'b0;
   logic rst;
   int   total;
   int   bad;

   rs_issue_select_if bus ();

   rs_issue_select dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   function automatic logic [19:0] idx5(input int a0, input int a1, input int m,
                                        input int me, input int b);
      return {4'(b), 4'(me), 4'(m), 4'(a1), 4'(a0)};
   endfunction

   task automatic apply_stimulus(input logic [15:0] alu, input logic [15:0] mul,
                                 input logic [15:0] mem, input logic [15:0] bcond,
                                 input logic stall, input logic fl);
      bus.wake_up_alu   = alu;
      bus.wake_up_mul   = mul;
      bus.wake_up_mem   = mem;
      bus.wake_up_bcond = bcond;
      bus.mem_stall     = stall;
      bus.flush         = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [4:0] ev,
                               input logic [19:0] ei, input logic [15:0] eu,
                               input logic eb);
      total++;
      assert (bus.issue_valid === ev) else begin
         bad++;
         $error("[TB] FAIL %s issue_valid observed=%b expected=%b", tag, bus.issue_valid, ev);
      end
      total++;
      assert (bus.issue_idx === ei) else begin
         bad++;
         $error("[TB] FAIL %s issue_idx observed=%h expected=%h", tag, bus.issue_idx, ei);
      end
      total++;
      assert (bus.rs_use_en === eu) else begin
         bad++;
         $error("[TB] FAIL %s rs_use_en observed=%h expected=%h", tag, bus.rs_use_en, eu);
      end
      total++;
      assert (bus.mul_busy === eb) else begin
         bad++;
         $error("[TB] FAIL %s mul_busy observed=%b expected=%b", tag, bus.mul_busy, eb);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      apply_stimulus(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      tick();
      check_output("reset", 5'b0, 20'h0, 16'h0, 1'b0);

      rst = 1'b0;
      tick();
      check_output("idle", 5'b0, 20'h0, 16'h0, 1'b0);

      // ALU pairing and pointer advance
      apply_stimulus(16'h0006, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check_output("alu_pair", 5'b00011, idx5(1, 2, 0, 0, 0), 16'h0006, 1'b0);
      apply_stimulus(16'h000F, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check_output("alu_rr3", 5'b00011, idx5(3, 0, 0, 0, 0), 16'h0009, 1'b0);
      apply_stimulus(16'h4000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check_output("alu_one", 5'b00001, idx5(14, 0, 0, 0, 0), 16'h4000, 1'b0);

      // ALU wrap from rr=15, then masking on the held vector
      apply_stimulus(16'h8001, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check_output("alu_wrap", 5'b00011, idx5(15, 0, 0, 0, 0), 16'h8001, 1'b0);
      tick();
      check_output("alu_masked", 5'b0, 20'h0, 16'h0, 1'b0);
      tick();
      check_output("alu_again", 5'b00011, idx5(15, 0, 0, 0, 0), 16'h8001, 1'b0);
      apply_stimulus(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check_output("alu_idle", 5'b0, 20'h0, 16'h0, 1'b0);

      // BCOND pointer wrap to 15 and then entry 0
      apply_stimulus(16'h0, 16'h0, 16'h0, 16'h4000, 1'b0, 1'b0);
      tick();
      check_output("bcond_14", 5'b10000, idx5(0, 0, 0, 0, 14), 16'h4000, 1'b0);
      apply_stimulus(16'h0, 16'h0, 16'h0, 16'h0001, 1'b0, 1'b0);
      tick();
      check_output("bcond_wrap", 5'b10000, idx5(0, 0, 0, 0, 0), 16'h0001, 1'b0);
      apply_stimulus(16'h0, 16'h0, 16'h0, 16'h8002, 1'b0, 1'b0);
      tick();
      check_output("bcond_ptr", 5'b10000, idx5(0, 0, 0, 0, 1), 16'h0002, 1'b0);
      apply_stimulus(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check_output("bcond_idle", 5'b0, 20'h0, 16'h0, 1'b0);

      // Multiplier occupancy
      apply_stimulus(16'h0, 16'h0011, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check_output("mul_grant0", 5'b00100, idx5(0, 0, 0, 0, 0), 16'h0001, 1'b1);
      tick();
      check_output("mul_busy2", 5'b0, 20'h0, 16'h0, 1'b1);
      tick();
      check_output("mul_busy3", 5'b0, 20'h0, 16'h0, 1'b1);
      tick();
      check_output("mul_free", 5'b0, 20'h0, 16'h0, 1'b0);
      tick();
      check_output("mul_grant4", 5'b00100, idx5(0, 0, 4, 0, 0), 16'h0010, 1'b1);
      apply_stimulus(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check_output("mul_count", 5'b0, 20'h0, 16'h0, 1'b1);
      tick();
      tick();
      check_output("mul_done", 5'b0, 20'h0, 16'h0, 1'b0);

      // Memory stall
      apply_stimulus(16'h0, 16'h0, 16'h0100, 16'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_output("mem_stall", 5'b0, 20'h0, 16'h0, 1'b0);
      end
      apply_stimulus(16'h0, 16'h0, 16'h0100, 16'h0, 1'b0, 1'b0);
      tick();
      check_output("mem_go", 5'b01000, idx5(0, 0, 0, 8, 0), 16'h0100, 1'b0);
      apply_stimulus(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check_output("mem_idle", 5'b0, 20'h0, 16'h0, 1'b0);

      // All classes at once, then flush, then recovery
      apply_stimulus(16'h0003, 16'h0020, 16'h0400, 16'h0800, 1'b0, 1'b0);
      tick();
      check_output("all_grant", 5'b11111, idx5(1, 0, 5, 10, 11), 16'h0C23, 1'b1);
      apply_stimulus(16'h0003, 16'h0020, 16'h0400, 16'h0800, 1'b0, 1'b1);
      tick();
      check_output("flush", 5'b0, 20'h0, 16'h0, 1'b0);
      apply_stimulus(16'h0003, 16'h0020, 16'h0400, 16'h0800, 1'b0, 1'b0);
      tick();
      check_output("post_flush", 5'b11111, idx5(1, 0, 5, 10, 11), 16'h0C23, 1'b1);

      // Reset during multiply and active grant
      rst = 1'b1;
      tick();
      check_output("mid_reset", 5'b0, 20'h0, 16'h0, 1'b0);
      rst = 1'b0;
      tick();
      check_output("post_reset", 5'b11111, idx5(0, 1, 5, 10, 11), 16'h0C23, 1'b1);
      apply_stimulus(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      tick();
      check_output("final_idle", 5'b0, 20'h0, 16'h0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rs_issue_select.md
RS_ISSUE_SELECT -- requirements
Module: rs_issue_select

Interface
REQ-001 Parameters: RS_SIZE, default 16, number of RS entries; RS_WIDTH, default 4, log2(RS_SIZE); MUL_LAT, default 4, multiplier occupancy in cycles.
REQ-002 clk  input  1  clock, rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  branch-mispredict squash.
REQ-005 wake_up_alu  input  RS_SIZE  per-entry ALU ready.
REQ-006 wake_up_mul  input  RS_SIZE  per-entry MUL ready.
REQ-007 wake_up_mem  input  RS_SIZE  per-entry MEM ready.
REQ-008 wake_up_bcond  input  RS_SIZE  per-entry BCOND ready.
REQ-009 mem_stall  input  1  memory unit cannot accept an op this cycle.
REQ-010 rs_use_en  output  RS_SIZE  per-entry issue enable, registered.
REQ-011 issue_valid  output  5  slot valid: [0] ALU0, [1] ALU1, [2] MUL, [3] MEM, [4] BCOND, registered.
REQ-012 issue_idx  output  5*RS_WIDTH  RS index per slot, slot k at bits [k*RS_WIDTH +: RS_WIDTH], registered.
REQ-013 mul_busy  output  1  multiplier occupied.

Function
REQ-014 Each cycle, candidates per class SHALL be wake_up_<class> AND NOT rs_use_en. This masks entries granted last cycle whose wake_up has not yet dropped.
REQ-015 ALU: up to two grants per cycle.
- ALU0 SHALL be the first candidate at or after rr_alu, searching upward with wrap.
- ALU1 SHALL be the next candidate after ALU0, searching with wrap, excluding ALU0.
REQ-016 MUL, MEM, BCOND: at most one grant each per cycle, selected by round-robin from rr_mul, rr_mem and rr_bcond respectively.
REQ-017 A round-robin pointer SHALL update to (last granted index of its class + 1) mod RS_SIZE. It SHALL stay unchanged when its class makes no grant.
REQ-018 MUL grant SHALL be suppressed while mul_busy=1. MEM grant SHALL be suppressed while mem_stall=1.
REQ-019 Grants SHALL be registered:
- issue_valid, issue_idx and rs_use_en appear exactly 1 cycle after the wake_up cycle.
- rs_use_en SHALL equal the OR of the one-hot decodes of all valid slots.
REQ-020 An entry SHALL never be granted to two slots in the same cycle. rs_use_en SHALL never be asserted for the same entry on two consecutive cycles.
REQ-021 issue_idx for a slot whose issue_valid=0 SHALL be 0.
REQ-022 MUL grant SHALL load mul_cnt with MUL_LAT-1.
- mul_busy=1 while mul_cnt!=0.
- mul_cnt decrements by 1 per cycle to 0.
- When MUL_LAT=1, mul_busy stays 0.
REQ-023 flush SHALL block new grants and clear all output registers on the next edge. It SHALL also clear mul_cnt. Round-robin pointers SHALL be unchanged.
REQ-024 A wake_up vector of all zeros SHALL produce issue_valid=0 next cycle and no pointer change.
REQ-025 Wrap-around: with rr=RS_SIZE-1 and only entry 0 ready, entry 0 SHALL be granted and rr SHALL become 1.

Reset
REQ-026 On rst, the following SHALL all be 0 on the next edge: rs_use_en, issue_valid, issue_idx, mul_cnt, mul_busy, all rr pointers.
REQ-027 rst asserted mid-multiply SHALL clear mul_busy immediately on that edge.
REQ-028 rst SHALL take priority over flush and over all grants.

Structure
REQ-029 RS_SIZE, RS_WIDTH, MUL_LAT and the slot index constants (SLOT_ALU0=0 .. SLOT_BCOND=4) SHALL live in the shared define file with the existing PRF/ROB widths.
REQ-030 Round-robin search SHALL be one reusable sub-module, rr_pick. It takes a request vector and a start pointer, and returns valid plus index. It is instantiated five times (ALU1 uses ALU0-masked requests).

Verification
REQ-031 wake_up_alu=16'h0006, rr_alu=0 -> next cycle ALU0 idx=1, ALU1 idx=2, rs_use_en=16'h0006, rr_alu=3.
REQ-032 wake_up_alu=16'h8001 held 2 cycles, rr_alu=15 -> cycle1 ALU0=15, ALU1=0; cycle2 no ALU grant (masked).
REQ-033 wake_up_mul=16'h0011, MUL_LAT=4 -> entry 0 granted; mul_busy high 3 cycles; entry 4 granted on the first cycle mul_busy=0.
REQ-034 wake_up_mem=16'h0100 with mem_stall=1 for 3 cycles -> no MEM grant; grant of idx 8 one cycle after mem_stall falls.
REQ-035 All classes ready and flush=1 -> next cycle issue_valid=0, rs_use_en=0, mul_busy=0.
REQ-036 rst asserted during mul_busy and during an active grant -> all outputs 0 next cycle; first grant after rst starts from index 0.
